// File: rtl/pack_32to128.sv
// Packs a stream of 32-bit words into 128-bit lines.
// A flush emits a zero-padded partial line whose lane mask is in arrival order.
module pack_32to128 #(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [127:0]     out_data,
    output logic [3:0]       out_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] lines_out
);

    logic [2:0][31:0] asm_q;
    logic [2:0]       cnt_q;
    logic             flush_pend_q;

    logic             slot_free;
    logic             accept;
    logic             consume;
    logic             load_full;
    logic             load_flush;
    logic [3:0][31:0] line_w;
    logic [3:0]       line_mask;
    logic [127:0]     line_data;

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = !flush_pend_q && ((cnt_q < 3'd3) || slot_free);
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign load_full  = accept && (cnt_q == 3'd3);
    assign load_flush = flush_pend_q && (cnt_q != '0) && slot_free;
    assign busy       = (cnt_q != '0) || flush_pend_q;

    // asm_q lanes above cnt_q are always zero, so a flush line needs no masking.
    always_comb begin
        line_w    = {32'h0, asm_q};
        line_mask = (4'd1 << cnt_q) - 4'd1;
        if (load_full) begin
            line_w[3] = in_data;
            line_mask = 4'hF;
        end
        line_data = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (LSB_FIRST)
                line_data[32*i +: 32] = line_w[i];
            else
                line_data[96-32*i +: 32] = line_w[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            out_data     <= '0;
            out_mask     <= '0;
            out_valid    <= 1'b0;
            lines_out    <= '0;
        end else begin
            if (load_full || load_flush) begin
                asm_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (cnt_q == 3'(i))
                        asm_q[i] <= in_data;
                end
                cnt_q <= cnt_q + 3'd1;
            end

            // A flush arriving while one is pending is ignored.
            if (flush_pend_q) begin
                if ((cnt_q == '0) || load_flush)
                    flush_pend_q <= 1'b0;
            end else if (flush) begin
                flush_pend_q <= 1'b1;
            end

            if (load_full || load_flush) begin
                out_data  <= line_data;
                out_mask  <= line_mask;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            if (consume)
                lines_out <= lines_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pack_32to128.sv
// Bench for pack_32to128: directed scenarios plus a randomized run against a
// word-queue reference model; a second instance covers LSB_FIRST=0 and counter wrap.
module tb_pack_32to128;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         flush;
    logic         out_ready;

    logic         in_ready,  in_ready_m;
    logic [127:0] out_data,  out_data_m;
    logic [3:0]   out_mask,  out_mask_m;
    logic         out_valid, out_valid_m;
    logic         busy,      busy_m;
    logic [15:0]  lines_out;
    logic [2:0]   lines_out_m;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pack_32to128 #(.LSB_FIRST(1'b1), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_mask(out_mask),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .lines_out(lines_out)
    );

    pack_32to128 #(.LSB_FIRST(1'b0), .CNT_W(3)) dut_m (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m), .out_mask(out_mask_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .busy(busy_m), .lines_out(lines_out_m)
    );

    // Expected line from words in arrival order w0..w3.
    function automatic logic [127:0] mk(input logic [31:0] w0, w1, w2, w3, input bit lsb);
        return lsb ? {w3, w2, w1, w0} : {w0, w1, w2, w3};
    endfunction

    task automatic clk_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        clk_edge();
        reset_n = 1'b1;
        clk_edge();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        clk_edge();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        tests++; if (out_mask !== 4'h0) begin fails++; $display("FAIL reset_out_mask: got %b want 0000", out_mask); end
        tests++; if (lines_out !== 16'h0) begin fails++; $display("FAIL reset_lines_out: got %0d want 0", lines_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        clk_edge();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_line();
        logic [31:0] w [4];
        w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = w[i];
            clk_edge();
            if (i == 2) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
            end
        end
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 128'h44444444_33333333_22222222_11111111) begin fails++; $display("FAIL single_data: got %h want 44444444333333332222222211111111", out_data); end
        tests++; if (out_mask !== 4'hF) begin fails++; $display("FAIL single_mask: got %b want 1111", out_mask); end
        tests++; if (out_data_m !== mk(w[0], w[1], w[2], w[3], 1'b0)) begin fails++; $display("FAIL single_data_msb: got %h want %h", out_data_m, mk(w[0], w[1], w[2], w[3], 1'b0)); end
        clk_edge();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
        tests++; if (lines_out !== 16'd1) begin fails++; $display("FAIL single_lines_out: got %0d want 1", lines_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wq [12];
        int          stalls = 0;
        int          b;
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) wq[k] = $urandom;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; in_data = wq[k];
            #1;
            if (in_ready !== 1'b1) stalls++;
            clk_edge();
            tests++; if (out_valid !== (k % 4 == 3)) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, (k % 4 == 3)); end
            if (k % 4 == 3) begin
                b = k - 3;
                tests++;
                if (out_data !== mk(wq[b], wq[b+1], wq[b+2], wq[b+3], 1'b1) || out_mask !== 4'hF) begin
                    fails++; $display("FAIL b2b_line[%0d]: got %h/%b want %h/1111", k / 4, out_data, out_mask, mk(wq[b], wq[b+1], wq[b+2], wq[b+3], 1'b1));
                end
            end
        end
        in_valid = 1'b0;
        tests++; if (stalls != 0) begin fails++; $display("FAIL b2b_in_ready: got %0d stalled cycles want 0", stalls); end
        clk_edge();
        tests++; if (lines_out !== 16'd3) begin fails++; $display("FAIL b2b_lines_out: got %0d want 3", lines_out); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] a [4];
        logic [31:0] bw [8];
        logic [127:0] line1, line2, line3;
        apply_reset();
        for (int k = 0; k < 4; k++) a[k] = $urandom;
        for (int k = 0; k < 8; k++) bw[k] = $urandom;
        line1 = mk(a[0], a[1], a[2], a[3], 1'b1);
        line2 = mk(bw[0], bw[1], bw[2], bw[3], 1'b1);
        line3 = mk(bw[4], bw[5], bw[6], bw[7], 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin in_valid = 1'b1; in_data = a[k]; clk_edge(); end
        for (int k = 0; k < 3; k++) begin in_data = bw[k]; clk_edge(); end
        in_data = bw[3];
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            clk_edge();
            tests++;
            if (out_valid !== 1'b1 || out_data !== line1 || out_mask !== 4'hF || in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_hold[%0d]: got v=%b %h/%b rdy=%b want v=1 %h/1111 rdy=0", k, out_valid, out_data, out_mask, in_ready, line1);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        clk_edge();
        tests++; if (out_valid !== 1'b1 || out_data !== line2) begin fails++; $display("FAIL stall_line2: got v=%b %h want v=1 %h", out_valid, out_data, line2); end
        tests++; if (lines_out !== 16'd1) begin fails++; $display("FAIL stall_lines1: got %0d want 1", lines_out); end
        for (int k = 4; k < 8; k++) begin in_data = bw[k]; clk_edge(); end
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_data !== line3) begin fails++; $display("FAIL stall_line3: got v=%b %h want v=1 %h", out_valid, out_data, line3); end
        tests++; if (lines_out !== 16'd2) begin fails++; $display("FAIL stall_lines2: got %0d want 2", lines_out); end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hA; clk_edge();
        in_data = 32'hB; clk_edge();
        in_valid = 1'b0; flush = 1'b1; clk_edge();
        flush = 1'b0;
        tests++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_pending: got rdy=%b busy=%b v=%b want 0 1 0", in_ready, busy, out_valid); end
        clk_edge();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 128'h0000000B_0000000A) begin fails++; $display("FAIL flush_data: got %h want 0000000b0000000a", out_data); end
        tests++; if (out_mask !== 4'b0011) begin fails++; $display("FAIL flush_mask: got %b want 0011", out_mask); end
        tests++; if (out_data_m !== mk(32'hA, 32'hB, 32'h0, 32'h0, 1'b0) || out_mask_m !== 4'b0011) begin fails++; $display("FAIL flush_msb: got %h/%b want %h/0011", out_data_m, out_mask_m, mk(32'hA, 32'hB, 32'h0, 32'h0, 1'b0)); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        clk_edge();
        flush = 1'b1; clk_edge();
        flush = 1'b0;
        tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty_pend: got busy=%b v=%b want 1 0", busy, out_valid); end
        clk_edge();
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || lines_out !== 16'd1) begin fails++; $display("FAIL flush_empty_done: got busy=%b v=%b lines=%0d want 0 0 1", busy, out_valid, lines_out); end
    endtask

    task automatic test_flush_with_word();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; clk_edge();
        in_data = 32'hB; clk_edge();
        in_data = 32'hC; flush = 1'b1; clk_edge();
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL fw_pending: got rdy=%b busy=%b want 0 1", in_ready, busy); end
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_mask !== 4'b0111 || out_data !== 128'h0000000C_0000000B_0000000A) begin
                fails++; $display("FAIL fw_line[%0d]: got v=%b %h/%b want v=1 0000000c0000000b0000000a/0111", k, out_valid, out_data, out_mask);
            end
            clk_edge();
        end
        out_ready = 1'b1;
        clk_edge();
        tests++; if (out_valid !== 1'b0 || lines_out !== 16'd1) begin fails++; $display("FAIL fw_consume: got v=%b lines=%0d want 0 1", out_valid, lines_out); end
    endtask

    task automatic test_lsb0_and_reset();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin in_valid = 1'b1; in_data = 32'(k); clk_edge(); end
        tests++; if (out_data_m !== 128'h00000001_00000002_00000003_00000004) begin fails++; $display("FAIL msb_data: got %h want 00000001000000020000000300000004", out_data_m); end
        tests++; if (out_data !== 128'h00000004_00000003_00000002_00000001) begin fails++; $display("FAIL lsb_data: got %h want 00000004000000030000000200000001", out_data); end
        in_data = 32'd5; clk_edge();
        in_data = 32'd6; clk_edge();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || out_data_m !== 128'h0 || out_mask !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_outputs: got v=%b %h %h m=%b busy=%b rdy=%b want all zero, rdy=1", out_valid, out_data, out_data_m, out_mask, busy, in_ready);
        end
        clk_edge();
        reset_n = 1'b1; out_ready = 1'b1;
        for (int k = 7; k <= 10; k++) begin in_valid = 1'b1; in_data = 32'(k); clk_edge(); end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_mask !== 4'hF || out_data !== mk(32'd7, 32'd8, 32'd9, 32'd10, 1'b1) || out_data_m !== mk(32'd7, 32'd8, 32'd9, 32'd10, 1'b0)) begin
            fails++; $display("FAIL midreset_clean_line: got v=%b %h/%b want v=1 %h/1111", out_valid, out_data, out_mask, mk(32'd7, 32'd8, 32'd9, 32'd10, 1'b1));
        end
        tests++; if (lines_out !== 16'd0) begin fails++; $display("FAIL midreset_lines: got %0d want 0", lines_out); end
    endtask

    task automatic test_random();
        int          mq [$];
        bit          m_fp = 1'b0, m_ov = 1'b0;
        logic [31:0] m_w [4];
        logic [31:0] nw [4];
        logic [3:0]  m_mask = '0, nmask;
        int unsigned m_lines = 0;
        bit          iv, fl, ordy, slot, ir, acc, cons, load, floaded;
        logic [31:0] d;
        int          n_old;
        for (int i = 0; i < 4; i++) m_w[i] = '0;
        apply_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            tests++; if (out_valid !== m_ov || out_valid_m !== m_ov) begin fails++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", cyc, out_valid, out_valid_m, m_ov); end
            if (m_ov) begin
                tests++;
                if (out_data !== mk(m_w[0], m_w[1], m_w[2], m_w[3], 1'b1) || out_data_m !== mk(m_w[0], m_w[1], m_w[2], m_w[3], 1'b0) || out_mask !== m_mask || out_mask_m !== m_mask) begin
                    fails++; $display("FAIL rnd_line[%0d]: got %h/%b want %h/%b", cyc, out_data, out_mask, mk(m_w[0], m_w[1], m_w[2], m_w[3], 1'b1), m_mask);
                end
            end
            tests++; if (busy !== (mq.size() != 0 || m_fp)) begin fails++; $display("FAIL rnd_busy[%0d]: got %b want %b", cyc, busy, (mq.size() != 0 || m_fp)); end
            tests++; if (lines_out !== m_lines[15:0] || lines_out_m !== m_lines[2:0]) begin fails++; $display("FAIL rnd_lines[%0d]: got %0d/%0d want %0d", cyc, lines_out, lines_out_m, m_lines); end

            iv = ($urandom_range(3) != 0); fl = ($urandom_range(11) == 0); ordy = ($urandom_range(2) != 0); d = $urandom;
            in_valid = iv; flush = fl; out_ready = ordy; in_data = d;
            slot = !m_ov || ordy;
            ir   = !m_fp && (mq.size() < 3 || slot);
            #1;
            tests++; if (in_ready !== ir || in_ready_m !== ir) begin fails++; $display("FAIL rnd_in_ready[%0d]: got %b/%b want %b", cyc, in_ready, in_ready_m, ir); end

            acc = iv && ir; cons = m_ov && ordy; load = 1'b0; floaded = 1'b0; n_old = mq.size();
            for (int i = 0; i < 4; i++) nw[i] = '0;
            nmask = '0;
            if (acc) begin
                mq.push_back(d);
                if (mq.size() == 4) begin
                    for (int i = 0; i < 4; i++) nw[i] = mq[i];
                    nmask = 4'hF; load = 1'b1; mq.delete();
                end
            end else if (m_fp && n_old > 0 && slot) begin
                for (int i = 0; i < n_old; i++) nw[i] = mq[i];
                nmask = 4'((1 << n_old) - 1); load = 1'b1; floaded = 1'b1; mq.delete();
            end
            if (m_fp) begin
                if (n_old == 0 || floaded) m_fp = 1'b0;
            end else if (fl) begin
                m_fp = 1'b1;
            end
            if (cons) m_lines++;
            if (load) begin
                m_ov = 1'b1; m_mask = nmask;
                for (int i = 0; i < 4; i++) m_w[i] = nw[i];
            end else if (cons) begin
                m_ov = 1'b0;
            end
            clk_edge();
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_stall();
        test_flush();
        test_flush_with_word();
        test_lsb0_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
